// File: rtl/jtag_bscan_tap.sv
// JTAG test-access block: 1149.1 TAP controller, instruction register, bypass/IDCODE/USERCODE
// data registers and an N_IO-pin boundary-scan register with a registered update stage.
//
// state  | meaning
// TLR    | test-logic-reset, instruction forced to IDCODE
// RTI    | run-test/idle
// SEL_*  | select DR / IR scan column
// CAP_*  | parallel load of the selected shift register
// SH_*   | serial shift, TDO driven
// EX*/PAU| exit / pause, shift registers hold
// UPD_*  | transfer shift register to its update stage
module jtag_bscan_tap #(
  parameter int          IR_WIDTH     = 4,
  parameter int          N_IO         = 4,
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [N_IO-1:0]     PAD_IN,
  input  logic [N_IO-1:0]     CORE_OUT,
  output logic [N_IO-1:0]     PAD_OUT,
  output logic                PAD_OE,
  output logic [N_IO-1:0]     CORE_IN,
  output logic [IR_WIDTH-1:0] IR_ACTIVE,
  output logic [3:0]          TAP_STATE
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  localparam int BSR_LEN = 2 * N_IO;

  localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(5);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(7);
  localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(8);
  localparam logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(9);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_active_q, ir_active_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         id_q, id_d;
  logic [BSR_LEN-1:0]  bsr_shift_q, bsr_shift_d;
  logic [BSR_LEN-1:0]  bsr_upd_q, bsr_upd_d;

  logic sel_bsr, sel_id;

  // Anything outside the BSR and id opcodes falls back to the bypass bit.
  assign sel_bsr = (ir_active_q == OP_SAMPLE) || (ir_active_q == OP_EXTEST) ||
                   (ir_active_q == OP_INTEST);
  assign sel_id  = (ir_active_q == OP_IDCODE) || (ir_active_q == OP_USERCODE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    ir_shift_d  = ir_shift_q;
    ir_active_d = ir_active_q;
    bypass_d    = bypass_q;
    id_d        = id_q;
    bsr_shift_d = bsr_shift_q;
    bsr_upd_d   = bsr_upd_q;
    case (state_q)
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR: ir_active_d = ir_shift_q;
      CAP_DR: begin
        if (sel_bsr)     bsr_shift_d = {CORE_OUT, PAD_IN};
        else if (sel_id) id_d = (ir_active_q == OP_USERCODE) ? USERCODE_VAL : IDCODE_VAL;
        else             bypass_d = 1'b0;
      end
      SH_DR: begin
        if (sel_bsr)     bsr_shift_d = {TDI, bsr_shift_q[BSR_LEN-1:1]};
        else if (sel_id) id_d = {TDI, id_q[31:1]};
        else             bypass_d = TDI;
      end
      UPD_DR: if (sel_bsr) bsr_upd_d = bsr_shift_q;
      default: ;
    endcase
    // Entering TLR by TMS alone must leave IDCODE active, same as a hard reset.
    if (state_d == TLR) ir_active_d = OP_IDCODE;
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q     <= TLR;
      ir_shift_q  <= '0;
      ir_active_q <= OP_IDCODE;
      bypass_q    <= 1'b0;
      id_q        <= '0;
      bsr_shift_q <= '0;
      bsr_upd_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_shift_q  <= ir_shift_d;
      ir_active_q <= ir_active_d;
      bypass_q    <= bypass_d;
      id_q        <= id_d;
      bsr_shift_q <= bsr_shift_d;
      bsr_upd_q   <= bsr_upd_d;
    end
  end

  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    if (state_q == SH_IR) begin
      TDO    = ir_shift_q[0];
      TDO_EN = 1'b1;
    end else if (state_q == SH_DR) begin
      TDO_EN = 1'b1;
      if (sel_bsr)     TDO = bsr_shift_q[0];
      else if (sel_id) TDO = id_q[0];
      else             TDO = bypass_q;
    end
  end

  assign PAD_OUT   = ((ir_active_q == OP_EXTEST) || (ir_active_q == OP_CLAMP)) ?
                     bsr_upd_q[BSR_LEN-1:N_IO] : CORE_OUT;
  assign CORE_IN   = (ir_active_q == OP_INTEST) ? bsr_upd_q[N_IO-1:0] : PAD_IN;
  assign PAD_OE    = (ir_active_q != OP_HIGHZ);
  assign IR_ACTIVE = ir_active_q;
  assign TAP_STATE = state_q;

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Directed bench for jtag_bscan_tap: TAP walking, IR/DR scans, boundary-scan pad muxing.
module tb_jtag_bscan_tap;
  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TMS = 1'b0;
  logic       TDI = 1'b0;
  logic       TDO, TDO_EN, PAD_OE;
  logic [3:0] PAD_IN = 4'h0;
  logic [3:0] CORE_OUT = 4'h0;
  logic [3:0] PAD_OUT, CORE_IN, IR_ACTIVE, TAP_STATE;

  int total = 0;
  int bad = 0;

  jtag_bscan_tap dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .PAD_IN(PAD_IN), .CORE_OUT(CORE_OUT), .PAD_OUT(PAD_OUT), .PAD_OE(PAD_OE),
    .CORE_IN(CORE_IN), .IR_ACTIVE(IR_ACTIVE), .TAP_STATE(TAP_STATE)
  );

  always #5 TCK = ~TCK;

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Starts and ends in RTI.
  task automatic load_ir(input logic [3:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
    tick(1, 0); tick(0, 0);
  endtask

  // Starts and ends in RTI; returns the TDO stream LSB first.
  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_reset;
    PAD_IN = 4'h9; CORE_OUT = 4'h6;
    TRST = 1'b1;
    tick(1, 1);
    TRST = 1'b0;
    total++; if (TAP_STATE !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", TAP_STATE); end
    total++; if (IR_ACTIVE !== 4'd7) begin bad++; $display("FAIL rst_ir got=%0h exp=7", IR_ACTIVE); end
    total++; if ({TDO, TDO_EN, PAD_OE} !== 3'b001) begin bad++; $display("FAIL rst_outs got=%b exp=001", {TDO, TDO_EN, PAD_OE}); end
    total++; if ({PAD_OUT, CORE_IN} !== 8'h69) begin bad++; $display("FAIL rst_pads got=%h exp=69", {PAD_OUT, CORE_IN}); end
  endtask

  task automatic test_idcode;
    logic [31:0] exp_id = 32'h1000_0001;
    logic [31:0] got = '0;
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    total++; if (TAP_STATE !== 4'd4 || TDO_EN !== 1'b1) begin bad++; $display("FAIL id_shdr state=%0d en=%b exp=4/1", TAP_STATE, TDO_EN); end
    for (int i = 0; i < 32; i++) begin
      got[i] = TDO;
      tick(i == 31, 0);
    end
    total++; if (got !== exp_id) begin bad++; $display("FAIL id_stream got=%h exp=%h", got, exp_id); end
    total++; if (TAP_STATE !== 4'd5) begin bad++; $display("FAIL id_ex1 got=%0d exp=5", TAP_STATE); end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_tlr_escape;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0);
    total++; if (TAP_STATE !== 4'd0 || IR_ACTIVE !== 4'd7 || TDO_EN !== 1'b0) begin
      bad++; $display("FAIL tms_escape state=%0d ir=%0h en=%b exp=0/7/0", TAP_STATE, IR_ACTIVE, TDO_EN);
    end
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    total++; if (TAP_STATE !== 4'd11) begin bad++; $display("FAIL shir_entry got=%0d exp=11", TAP_STATE); end
    TRST = 1'b1;
    tick(0, 1);
    TRST = 1'b0;
    total++; if (TAP_STATE !== 4'd0 || TDO_EN !== 1'b0) begin bad++; $display("FAIL trst_mid got=%0d en=%b exp=0/0", TAP_STATE, TDO_EN); end
    tick(0, 0);
  endtask

  task automatic test_bypass;
    logic [3:0] rb = '0;
    logic [31:0] got;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      rb[i] = TDO;
      tick(i == 3, 1);
    end
    tick(1, 0); tick(0, 0);
    total++; if (rb !== 4'b0001) begin bad++; $display("FAIL ir_capture got=%b exp=0001", rb); end
    total++; if (IR_ACTIVE !== 4'hF) begin bad++; $display("FAIL ir_bypass got=%h exp=f", IR_ACTIVE); end
    shift_dr(32'hD, 4, got);
    total++; if (got[3:0] !== 4'hA) begin bad++; $display("FAIL bypass_delay got=%h exp=a", got[3:0]); end
    load_ir(4'h4);
    shift_dr(32'h3, 3, got);
    total++; if (got[2:0] !== 3'b110) begin bad++; $display("FAIL unknown_op got=%b exp=110", got[2:0]); end
  endtask

  task automatic test_sample;
    logic [31:0] got;
    PAD_IN = 4'hA; CORE_OUT = 4'h5;
    load_ir(4'h1);
    shift_dr(32'h0, 8, got);
    total++; if (got[7:0] !== 8'h5A) begin bad++; $display("FAIL sample_cap got=%h exp=5a", got[7:0]); end
    total++; if (PAD_OUT !== 4'h5 || CORE_IN !== 4'hA) begin bad++; $display("FAIL sample_pass out=%h in=%h exp=5/a", PAD_OUT, CORE_IN); end
  endtask

  task automatic test_extest_intest;
    logic [31:0] got;
    shift_dr(32'h3C, 8, got);
    total++; if (PAD_OUT !== 4'h5) begin bad++; $display("FAIL preload_hold got=%h exp=5", PAD_OUT); end
    load_ir(4'h2);
    total++; if (PAD_OUT !== 4'h3) begin bad++; $display("FAIL extest_out got=%h exp=3", PAD_OUT); end
    CORE_OUT = 4'hF; #1;
    total++; if (PAD_OUT !== 4'h3 || CORE_IN !== 4'hA) begin bad++; $display("FAIL extest_core out=%h in=%h exp=3/a", PAD_OUT, CORE_IN); end
    load_ir(4'h3);
    total++; if (CORE_IN !== 4'hC || PAD_OUT !== 4'hF) begin bad++; $display("FAIL intest in=%h out=%h exp=c/f", CORE_IN, PAD_OUT); end
  endtask

  task automatic test_highz_clamp;
    logic [31:0] got;
    load_ir(4'h9);
    total++; if (PAD_OE !== 1'b0 || PAD_OUT !== 4'hF) begin bad++; $display("FAIL highz oe=%b out=%h exp=0/f", PAD_OE, PAD_OUT); end
    shift_dr(32'h1, 4, got);
    total++; if (got[3:0] !== 4'b0010) begin bad++; $display("FAIL highz_bypass got=%b exp=0010", got[3:0]); end
    load_ir(4'h5);
    total++; if (PAD_OE !== 1'b1 || PAD_OUT !== 4'h3 || CORE_IN !== 4'hA) begin
      bad++; $display("FAIL clamp oe=%b out=%h in=%h exp=1/3/a", PAD_OE, PAD_OUT, CORE_IN);
    end
  endtask

  task automatic test_usercode_pause;
    logic [31:0] got;
    load_ir(4'h8);
    shift_dr(32'hFFFF_FFFF, 32, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL usercode got=%h exp=0", got); end
    load_ir(4'h7);
    shift_dr(32'h0, 32, got);
    total++; if (got !== 32'h1000_0001) begin bad++; $display("FAIL idcode_reload got=%h exp=10000001", got); end
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 28; i++) tick(i == 27, 0);
    tick(0, 1);
    total++; if (TAP_STATE !== 4'd6 || TDO_EN !== 1'b0 || TDO !== 1'b0) begin
      bad++; $display("FAIL pause state=%0d en=%b tdo=%b exp=6/0/0", TAP_STATE, TDO_EN, TDO);
    end
    tick(0, 1); tick(1, 1); tick(0, 1);
    total++; if (TAP_STATE !== 4'd4 || TDO !== 1'b1) begin bad++; $display("FAIL pause_hold state=%0d tdo=%b exp=4/1", TAP_STATE, TDO); end
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_tlr_escape();
    test_bypass();
    test_sample();
    test_extest_intest();
    test_highz_clamp();
    test_usercode_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
